unidade_controle_drone: RTL and testbench
=========================================

# unidade_controle_drone

Control FSM for the drone game. Paces each move with the move timer and latches the player's up/down choice during the wait window. Issues one displacement pulse per move and judges collision and end-of-map after every step. Drives the game datapath's `desloca`, `zeraPosicoes`, `contaT`, `zeraT` and `controle`, and consumes its `colisao`, `fim_espera` and `fim_mapa`.

## Interface
Parameters: none.
- `clock` in 1: single system clock, rising edge
- `reset` in 1: synchronous, active-high; forces INICIAL
- `iniciar` in 1: start/restart request, level
- `botao_cima` in 1: up button; synchronous, debounced level
- `botao_baixo` in 1: down button; synchronous, debounced level
- `colisao` in 1: datapath collision flag
- `fim_espera` in 1: move timer terminal count
- `fim_mapa` in 1: horizontal position at last column
- `desloca` out 1: one-cycle move strobe
- `zeraPosicoes` out 1: reload positions (horizontal 0, vertical 2)
- `contaT` out 1: move timer enable
- `zeraT` out 1: move timer synchronous clear
- `controle` out 2: bit0 = up (soma), bit1 = down (sub)
- `pronto` out 1: game over, result valid
- `ganhou` out 1: map completed
- `perdeu` out 1: collision
- `db_estado` out 4: current state code

## Operation
State codes: INICIAL=0, PREPARA=1, ESPERA=2, MOVE=3, AGUARDA=4, VERIFICA=5, GANHOU=6, PERDEU=7.

- INICIAL: all outputs 0. `iniciar`=1 → PREPARA.
- PREPARA (1 cycle): `zeraPosicoes`=1, `zeraT`=1, jogada register ← 00. → ESPERA.
- ESPERA: `contaT`=1.
  - Rising edge of a button loads jogada (cima → 01, baixo → 10), but only while jogada = 00. The first press wins; later presses are ignored.
  - Both edges in the same cycle: ignored, jogada unchanged.
  - `fim_espera`=1 → MOVE.
- MOVE (1 cycle): `desloca`=1, `controle`=jogada, `zeraT`=1. → AGUARDA.
- AGUARDA (1 cycle): no strobes. Covers the datapath's synchronous map read. → VERIFICA.
- VERIFICA (1 cycle), priority order:
  1. `colisao`=1 → PERDEU.
  2. Else `fim_mapa`=1 → GANHOU.
  3. Else → ESPERA with jogada ← 00.
- GANHOU / PERDEU: hold. `pronto`=1; `ganhou` or `perdeu`=1 respectively. `iniciar`=1 → PREPARA.

Other rules:
- `controle` is 00 in every state except MOVE.
- `iniciar` is ignored in PREPARA through VERIFICA.
- Edge detector: a previous-value register per button. Edge = current & ~previous.
- Previous registers load 1 on reset, so a button held through reset produces no edge.
- Previous registers update every cycle in every state, so a press held from GANHOU/PERDEU into ESPERA does not count as an edge.

## Timing
- All outputs are Moore, decoded from the state register. `db_estado` equals the state code.
- Reset values: state INICIAL; jogada 00; all outputs 0; `db_estado`=0.
- Reset asserted in any state: INICIAL on the next edge; no strobe that cycle.
- Start latency: `iniciar` sampled in INICIAL → PREPARA the next cycle → ESPERA the cycle after.
- Move cadence: MOVE is entered the cycle after `fim_espera` is sampled in ESPERA. `colisao` and `fim_mapa` are sampled exactly 2 cycles after the `desloca` cycle.
- Per-move overhead beyond the timer: 3 cycles (MOVE, AGUARDA, VERIFICA).
- A press whose rising edge is sampled in the same cycle `fim_espera` is seen is accepted, and applies in that MOVE.

## Structure
- Package `drone_pkg`:
  - state enum with the codes above;
  - `CONTROLE_NADA`=00, `CONTROLE_CIMA`=01, `CONTROLE_BAIXO`=10.
- Sub-module `detector_borda`: one-bit rising-edge detector with synchronous reset-to-1 of its previous register. Instantiated once per button.
- Top level: state register, next-state logic, jogada register, output decode.

## Test plan
- Reset mid-ESPERA with `botao_cima` held → next cycle `db_estado`=0, outputs 0. After `iniciar`, no jogada loads until the button is released and pressed again.
- `iniciar` pulse, up press in ESPERA, `fim_espera` pulse → exactly one cycle with `desloca`=1, `controle`=01, `zeraT`=1. `db_estado` sequence 2,3,4,5,2.
- Up then down press in the same ESPERA → `controle`=01 at MOVE. Both edges in one cycle → `controle`=00.
- `colisao`=1 and `fim_mapa`=1 together in VERIFICA → state 7, `perdeu`=1, `ganhou`=0, `pronto`=1, held until `iniciar`.
- `fim_mapa`=1, `colisao`=0 in VERIFICA → state 6, `ganhou`=1. Then `iniciar` → PREPARA with `zeraPosicoes`=1 for one cycle.
- Press with edge in the same cycle as `fim_espera` → accepted; `controle`=10 (down) in the following MOVE.

Source files
------------

// File: rtl/unidade_controle_drone_pkg.sv
// Shared types for the drone game controller: state codes, move codes
// and the Moore output decode used by the top level.
package drone_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        ESPERA   = 4'd2,
        MOVE     = 4'd3,
        AGUARDA  = 4'd4,
        VERIFICA = 4'd5,
        GANHOU   = 4'd6,
        PERDEU   = 4'd7
    } estado_t;

    localparam logic [1:0] CONTROLE_NADA  = 2'b00;
    localparam logic [1:0] CONTROLE_CIMA  = 2'b01;
    localparam logic [1:0] CONTROLE_BAIXO = 2'b10;

    typedef struct packed {
        logic       desloca;
        logic       zeraPosicoes;
        logic       contaT;
        logic       zeraT;
        logic [1:0] controle;
        logic       pronto;
        logic       ganhou;
        logic       perdeu;
    } saidas_t;

    // Output pattern of a state; controle carries the latched move only in MOVE.
    function automatic saidas_t decodifica_saidas(estado_t estado, logic [1:0] jogada);
        saidas_t s;
        s = '0;
        case (estado)
            INICIAL:  s = '0;
            PREPARA: begin
                s.zeraPosicoes = 1'b1;
                s.zeraT        = 1'b1;
            end
            ESPERA:   s.contaT = 1'b1;
            MOVE: begin
                s.desloca  = 1'b1;
                s.zeraT    = 1'b1;
                s.controle = jogada;
            end
            AGUARDA:  s = '0;
            VERIFICA: s = '0;
            GANHOU: begin
                s.pronto = 1'b1;
                s.ganhou = 1'b1;
            end
            PERDEU: begin
                s.pronto = 1'b1;
                s.perdeu = 1'b1;
            end
            default:  s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_drone_if.sv
// Strobe/flag bundle between the drone controller (master) and the game
// datapath (slave).
interface unidade_controle_drone_if;

    logic       desloca;
    logic       zeraPosicoes;
    logic       contaT;
    logic       zeraT;
    logic [1:0] controle;
    logic       colisao;
    logic       fim_espera;
    logic       fim_mapa;

    modport master (
        output desloca, zeraPosicoes, contaT, zeraT, controle,
        input  colisao, fim_espera, fim_mapa
    );

    modport slave (
        input  desloca, zeraPosicoes, contaT, zeraT, controle,
        output colisao, fim_espera, fim_mapa
    );

endinterface

// File: rtl/unidade_controle_drone_detector_borda.sv
// One-bit rising-edge detector; the previous-value register resets to 1 so a
// level already high when reset releases is not seen as a new press.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic borda
);

    logic anterior_r;

    // Previous-value register, updated every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            anterior_r <= 1'b1;
        end else begin
            anterior_r <= sinal;
        end
    end

    assign borda = sinal & ~anterior_r;

endmodule

// File: rtl/unidade_controle_drone.sv
// Drone game control FSM: paces moves with the move timer, latches the first
// button press per move and judges collision / end of map after each step.
module unidade_controle_drone
    import drone_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      botao_cima,
    input  logic                      botao_baixo,
    unidade_controle_drone_if.master  dp,
    output logic                      pronto,
    output logic                      ganhou,
    output logic                      perdeu,
    output logic [3:0]                db_estado
);

    estado_t    state_r;
    estado_t    state_s;
    logic [1:0] jogada_r;
    logic [1:0] jogada_s;
    saidas_t    saidas_r;
    logic       borda_cima_s;
    logic       borda_baixo_s;

    detector_borda u_borda_cima (
        .clock (clock),
        .reset (reset),
        .sinal (botao_cima),
        .borda (borda_cima_s)
    );

    detector_borda u_borda_baixo (
        .clock (clock),
        .reset (reset),
        .sinal (botao_baixo),
        .borda (borda_baixo_s)
    );

    // Next-state and next-jogada logic.
    always_comb begin
        state_s  = state_r;
        jogada_s = jogada_r;
        case (state_r)
            INICIAL: begin
                if (iniciar) state_s = PREPARA;
                else         state_s = INICIAL;
            end
            PREPARA: begin
                jogada_s = CONTROLE_NADA;
                state_s  = ESPERA;
            end
            ESPERA: begin
                // Simultaneous edges are ambiguous and leave jogada untouched.
                if ((jogada_r == CONTROLE_NADA) && (borda_cima_s ^ borda_baixo_s)) begin
                    jogada_s = borda_cima_s ? CONTROLE_CIMA : CONTROLE_BAIXO;
                end else begin
                    jogada_s = jogada_r;
                end
                if (dp.fim_espera) state_s = MOVE;
                else               state_s = ESPERA;
            end
            MOVE:    state_s = AGUARDA;
            AGUARDA: state_s = VERIFICA;
            VERIFICA: begin
                if (dp.colisao) begin
                    state_s = PERDEU;
                end else if (dp.fim_mapa) begin
                    state_s = GANHOU;
                end else begin
                    state_s  = ESPERA;
                    jogada_s = CONTROLE_NADA;
                end
            end
            GANHOU, PERDEU: begin
                if (iniciar) state_s = PREPARA;
                else         state_s = state_r;
            end
            default: begin
                state_s  = INICIAL;
                jogada_s = CONTROLE_NADA;
            end
        endcase
    end

    // State, jogada and output registers; outputs are decoded one cycle ahead
    // from the next state so they stay aligned with state_r.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= INICIAL;
            jogada_r <= CONTROLE_NADA;
            saidas_r <= '0;
        end else begin
            state_r  <= state_s;
            jogada_r <= jogada_s;
            saidas_r <= decodifica_saidas(state_s, jogada_s);
        end
    end

    assign dp.desloca      = saidas_r.desloca;
    assign dp.zeraPosicoes = saidas_r.zeraPosicoes;
    assign dp.contaT       = saidas_r.contaT;
    assign dp.zeraT        = saidas_r.zeraT;
    assign dp.controle     = saidas_r.controle;
    assign pronto          = saidas_r.pronto;
    assign ganhou          = saidas_r.ganhou;
    assign perdeu          = saidas_r.perdeu;
    assign db_estado       = state_r;

endmodule

// File: tb/tb_unidade_controle_drone.sv
// Directed bench for unidade_controle_drone: linear stimulus, hand-computed
// expected state codes and output patterns.
module tb_unidade_controle_drone;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       botao_cima;
    logic       botao_baixo;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] db_estado;

    int n_tests;
    int n_fail;

    unidade_controle_drone_if dp ();

    unidade_controle_drone dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .botao_cima  (botao_cima),
        .botao_baixo (botao_baixo),
        .dp          (dp),
        .pronto      (pronto),
        .ganhou      (ganhou),
        .perdeu      (perdeu),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {desloca, zeraPosicoes, contaT, zeraT, controle[1:0], pronto, ganhou, perdeu}
    logic [8:0] outs;
    assign outs = {dp.desloca, dp.zeraPosicoes, dp.contaT, dp.zeraT, dp.controle,
                   pronto, ganhou, perdeu};

    localparam logic [8:0] O_ZERO    = 9'b0_0_0_0_00_000;
    localparam logic [8:0] O_PREPARA = 9'b0_1_0_1_00_000;
    localparam logic [8:0] O_ESPERA  = 9'b0_0_1_0_00_000;
    localparam logic [8:0] O_MOVE_00 = 9'b1_0_0_1_00_000;
    localparam logic [8:0] O_MOVE_01 = 9'b1_0_0_1_01_000;
    localparam logic [8:0] O_MOVE_10 = 9'b1_0_0_1_10_000;
    localparam logic [8:0] O_GANHOU  = 9'b0_0_0_0_00_110;
    localparam logic [8:0] O_PERDEU  = 9'b0_0_0_0_00_101;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_st, input logic [8:0] exp_out);
        n_tests++;
        assert (db_estado === exp_st) else begin
            n_fail++;
            $error("FAIL %s state: got %0d expected %0d", tag, db_estado, exp_st);
        end
        n_tests++;
        assert (outs === exp_out) else begin
            n_fail++;
            $error("FAIL %s outs: got %b expected %b", tag, outs, exp_out);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; iniciar = 1'b0; botao_cima = 1'b0; botao_baixo = 1'b0;
        dp.colisao = 1'b0; dp.fim_espera = 1'b0; dp.fim_mapa = 1'b0;
        tick(); tick();
        chk("reset", 4'd0, O_ZERO);
        reset = 1'b0;
        tick();
        chk("idle", 4'd0, O_ZERO);

        // Basic move: up press then timer end.
        iniciar = 1'b1; tick();
        chk("prepara", 4'd1, O_PREPARA);
        iniciar = 1'b0; tick();
        chk("espera", 4'd2, O_ESPERA);
        botao_cima = 1'b1; tick();
        chk("espera_press", 4'd2, O_ESPERA);
        botao_cima = 1'b0; dp.fim_espera = 1'b1; tick();
        chk("move_up", 4'd3, O_MOVE_01);
        dp.fim_espera = 1'b0; tick();
        chk("aguarda", 4'd4, O_ZERO);
        tick();
        chk("verifica", 4'd5, O_ZERO);
        tick();
        chk("back_espera", 4'd2, O_ESPERA);

        // Up then down in one wait window: first press wins.
        botao_cima = 1'b1; tick();
        botao_cima = 1'b0; botao_baixo = 1'b1; tick();
        botao_baixo = 1'b0; dp.fim_espera = 1'b1; tick();
        chk("first_wins", 4'd3, O_MOVE_01);
        dp.fim_espera = 1'b0; tick(); tick(); tick();
        chk("espera2", 4'd2, O_ESPERA);

        // Both edges in the same cycle: ignored.
        botao_cima = 1'b1; botao_baixo = 1'b1; tick();
        botao_cima = 1'b0; botao_baixo = 1'b0; dp.fim_espera = 1'b1; tick();
        chk("both_edges", 4'd3, O_MOVE_00);
        dp.fim_espera = 1'b0; tick(); tick(); tick();
        chk("espera3", 4'd2, O_ESPERA);

        // Down edge in the same cycle as fim_espera, then collision + end of map.
        botao_baixo = 1'b1; dp.fim_espera = 1'b1; tick();
        chk("edge_with_fim", 4'd3, O_MOVE_10);
        botao_baixo = 1'b0; dp.fim_espera = 1'b0; tick(); tick();
        chk("verifica_lose", 4'd5, O_ZERO);
        dp.colisao = 1'b1; dp.fim_mapa = 1'b1; tick();
        chk("perdeu", 4'd7, O_PERDEU);
        dp.colisao = 1'b0; dp.fim_mapa = 1'b0; tick(); tick();
        chk("perdeu_hold", 4'd7, O_PERDEU);
        iniciar = 1'b1; tick();
        chk("restart_lose", 4'd1, O_PREPARA);
        iniciar = 1'b0; tick();
        chk("espera4", 4'd2, O_ESPERA);

        // Win path: no press, end of map.
        dp.fim_espera = 1'b1; tick();
        chk("move_none", 4'd3, O_MOVE_00);
        dp.fim_espera = 1'b0; tick(); tick();
        dp.fim_mapa = 1'b1; tick();
        chk("ganhou", 4'd6, O_GANHOU);
        dp.fim_mapa = 1'b0; tick();
        chk("ganhou_hold", 4'd6, O_GANHOU);
        iniciar = 1'b1; tick();
        chk("restart_win", 4'd1, O_PREPARA);
        iniciar = 1'b0; tick();
        chk("zera_one_cycle", 4'd2, O_ESPERA);

        // Reset mid-ESPERA with up held; held button must not load after restart.
        botao_cima = 1'b1; tick();
        reset = 1'b1; tick();
        chk("reset_mid", 4'd0, O_ZERO);
        reset = 1'b0; tick();
        chk("after_reset", 4'd0, O_ZERO);
        iniciar = 1'b1; tick();
        iniciar = 1'b0; tick();
        chk("espera5", 4'd2, O_ESPERA);
        tick();
        dp.fim_espera = 1'b1; tick();
        chk("held_no_edge", 4'd3, O_MOVE_00);
        dp.fim_espera = 1'b0; tick(); tick(); tick();
        botao_cima = 1'b0; tick();
        botao_cima = 1'b1; tick();
        botao_cima = 1'b0; dp.fim_espera = 1'b1; tick();
        chk("repress", 4'd3, O_MOVE_01);
        dp.fim_espera = 1'b0; tick();
        chk("aguarda_end", 4'd4, O_ZERO);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
